// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshake and full
// backpressure. Stage 0 registers per-bit generate/propagate. Each middle stage
// registers the group G/P after LVL_PER_STG prefix levels. The last register
// holds the finished sum, carry-out, signed-overflow flag and tag.
module ks_adder_pipe #(
  parameter int WIDTH       = 16,
  parameter int LVL_PER_STG = 2,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [TAG_W-1:0] tag_out
);

  localparam int L      = $clog2(WIDTH);
  localparam int NSTAGE = (L + LVL_PER_STG - 1) / LVL_PER_STG + 1;
  // number of stages that still carry prefix state (all but the result stage)
  localparam int NPRE   = NSTAGE - 1;

  if (WIDTH < 2)       begin : g_bad_width $error("WIDTH must be >= 2");       end
  if (LVL_PER_STG < 1) begin : g_bad_lvl   $error("LVL_PER_STG must be >= 1"); end
  if (TAG_W < 1)       begin : g_bad_tag   $error("TAG_W must be >= 1");       end

  // Apply Kogge-Stone levels lo..hi-1 (span 2^level) to a group G/P pair.
  // Levels at or beyond L are never applied, so hi may overshoot.
  function automatic logic [2*WIDTH-1:0] ks_levels(
    input logic [WIDTH-1:0] g_in,
    input logic [WIDTH-1:0] p_in,
    input int               lo,
    input int               hi
  );
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g_nx;
    logic [WIDTH-1:0] p_nx;
    int               span;
    g = g_in;
    p = p_in;
    for (int lv = 0; lv < L; lv++) begin
      if (lv >= lo && lv < hi) begin
        span = 1 << lv;
        g_nx = g;
        p_nx = p;
        for (int i = 0; i < WIDTH; i++) begin
          if (i >= span) begin
            g_nx[i] = g[i] | (p[i] & g[i-span]);
            p_nx[i] = p[i] & p[i-span];
          end
        end
        g = g_nx;
        p = p_nx;
      end
    end
    return {g, p};
  endfunction

  // Form carries from fully-resolved group G/P and c0.
  // The result is packed as {ovf, cout, sum}.
  function automatic logic [WIDTH+1:0] ks_result(
    input logic [WIDTH-1:0] g,
    input logic [WIDTH-1:0] p,
    input logic [WIDTH-1:0] p0,
    input logic             c0
  );
    logic [WIDTH:0] c;
    c[0] = c0;
    for (int i = 0; i < WIDTH; i++) begin
      c[i+1] = g[i] | (p[i] & c0);
    end
    return {c[WIDTH-1] ^ c[WIDTH], c[WIDTH], p0 ^ c[WIDTH-1:0]};
  endfunction

  logic [NSTAGE-1:0] vld_p;
  logic [NSTAGE-1:0] adv;
  logic [NSTAGE-1:0] load;
  logic              accept;

  logic [WIDTH-1:0]  b_eff;
  logic              c0_in;

  logic [WIDTH-1:0]  gg_p  [NPRE];
  logic [WIDTH-1:0]  pg_p  [NPRE];
  logic [WIDTH-1:0]  p0_p  [NPRE];
  logic              c0_p  [NPRE];
  logic [TAG_W-1:0]  tag_p [NPRE];

  logic [WIDTH-1:0]  gg_nx  [NPRE];
  logic [WIDTH-1:0]  pg_nx  [NPRE];
  logic [WIDTH-1:0]  p0_nx  [NPRE];
  logic              c0_nx  [NPRE];
  logic [TAG_W-1:0]  tag_nx [NPRE];

  logic [WIDTH-1:0]  g_fin;
  logic [WIDTH-1:0]  p_fin;
  logic [WIDTH+1:0]  res;

  // Subtraction is A + ~B + 1, so sub forces the carry-in high.
  assign b_eff = sub ? ~B : B;
  assign c0_in = sub | cin;

  // Advance chain, resolved from the output end back toward the input.
  // A stage moves when it holds data and the next stage is empty or moving.
  always_comb begin
    adv = '0;
    adv[NSTAGE-1] = vld_p[NSTAGE-1] & out_ready;
    for (int k = NSTAGE - 2; k >= 0; k--) begin
      adv[k] = vld_p[k] & (~vld_p[k+1] | adv[k+1]);
    end
  end

  assign in_ready  = ~rst & (~vld_p[0] | adv[0]);
  assign accept    = in_valid & in_ready;
  // stage k is written when its upstream neighbour hands data forward
  assign load      = {adv[NSTAGE-2:0], accept};
  assign out_valid = vld_p[NSTAGE-1];

  // Stage valid bits: set by an incoming load, cleared when the stage empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p <= load | (vld_p & ~adv);
    end
  end

  // Next-state values for every prefix-holding stage.
  always_comb begin
    // ---- stage 0: per-bit generate / propagate ----
    gg_nx[0]  = A & b_eff;
    pg_nx[0]  = A ^ b_eff;
    p0_nx[0]  = A ^ b_eff;
    c0_nx[0]  = c0_in;
    tag_nx[0] = tag_in;
    // ---- stages 1..NPRE-1: LVL_PER_STG prefix levels each ----
    for (int k = 1; k < NPRE; k++) begin
      {gg_nx[k], pg_nx[k]} = ks_levels(gg_p[k-1], pg_p[k-1],
                                       (k - 1) * LVL_PER_STG, k * LVL_PER_STG);
      p0_nx[k]  = p0_p[k-1];
      c0_nx[k]  = c0_p[k-1];
      tag_nx[k] = tag_p[k-1];
    end
  end

  // Prefix pipeline registers. They only change on a load, so a stalled stage
  // keeps its contents without needing a reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NPRE; k++) begin
      if (load[k]) begin
        gg_p[k]  <= gg_nx[k];
        pg_p[k]  <= pg_nx[k];
        p0_p[k]  <= p0_nx[k];
        c0_p[k]  <= c0_nx[k];
        tag_p[k] <= tag_nx[k];
      end
    end
  end

  // Remaining prefix levels plus carry/sum formation feed the result register.
  always_comb begin
    // ---- stage NSTAGE-1: last (possibly partial) set of levels and sum ----
    {g_fin, p_fin} = ks_levels(gg_p[NPRE-1], pg_p[NPRE-1],
                               (NPRE - 1) * LVL_PER_STG, L);
    res = ks_result(g_fin, p_fin, p0_p[NPRE-1], c0_p[NPRE-1]);
  end

  // Result register. Outputs come only from here and stay still while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      tag_out <= '0;
    end else if (load[NSTAGE-1]) begin
      {ovf, cout, sum} <= res;
      tag_out          <= tag_p[NPRE-1];
    end
  end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Directed bench for ks_adder_pipe. It covers the default 16-bit build, plus a
// 32-bit six-stage build and a 13-bit two-stage build.
`timescale 1ns/1ps
module tb_ks_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // default build: WIDTH=16, LVL_PER_STG=2 -> NSTAGE=3
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;
  logic [3:0]  tag_in, tag_out;

  ks_adder_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .cin(cin), .sub(sub), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .ovf(ovf), .tag_out(tag_out)
  );

  // WIDTH=32, LVL_PER_STG=1 -> NSTAGE=6
  logic        xin_valid, xin_ready, xcin, xsub, xout_valid, xout_ready, xcout, xovf;
  logic [31:0] xa, xb, xsum;
  logic [3:0]  xtag_in, xtag_out;

  ks_adder_pipe #(.WIDTH(32), .LVL_PER_STG(1), .TAG_W(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(xin_valid), .in_ready(xin_ready),
    .A(xa), .B(xb), .cin(xcin), .sub(xsub), .tag_in(xtag_in),
    .out_valid(xout_valid), .out_ready(xout_ready), .sum(xsum), .cout(xcout),
    .ovf(xovf), .tag_out(xtag_out)
  );

  // WIDTH=13, LVL_PER_STG=4 -> NSTAGE=2
  logic        yin_valid, yin_ready, ycin, ysub, yout_valid, yout_ready, ycout, yovf;
  logic [12:0] ya, yb, ysum;
  logic [3:0]  ytag_in, ytag_out;

  ks_adder_pipe #(.WIDTH(13), .LVL_PER_STG(4), .TAG_W(4)) dut13 (
    .clk(clk), .rst(rst), .in_valid(yin_valid), .in_ready(yin_ready),
    .A(ya), .B(yb), .cin(ycin), .sub(ysub), .tag_in(ytag_in),
    .out_valid(yout_valid), .out_ready(yout_ready), .sum(ysum), .cout(ycout),
    .ovf(yovf), .tag_out(ytag_out)
  );

  int          nchk = 0;
  int          nerr = 0;
  logic [21:0] sb[$];
  logic [21:0] cur, held, exp_in;
  logic        acc, xfr, stalled;
  int          sent, got, first, last;

  task automatic chk(input string nm, input logic [63:0] observed, input logic [63:0] expected);
    nchk++;
    assert (observed === expected) else begin
      nerr++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", nm, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [21:0] obs();
    return {tag_out, ovf, cout, sum};
  endfunction

  // Arithmetic reference: a plain 17-bit add, with overflow taken from operand signs.
  function automatic logic [21:0] model(input logic [15:0] va, input logic [15:0] vb,
                                        input logic vc, input logic vs, input logic [3:0] vt);
    logic [15:0] bb;
    logic        c0;
    logic [16:0] full;
    logic        o;
    bb   = vs ? ~vb : vb;
    c0   = vs ? 1'b1 : vc;
    full = {1'b0, va} + {1'b0, bb} + {16'b0, c0};
    o    = (va[15] == bb[15]) && (full[15] != va[15]);
    return {vt, o, full[16], full[15:0]};
  endfunction

  task automatic single(input string nm, input logic [15:0] va, input logic [15:0] vb,
                        input logic vc, input logic vs, input logic [3:0] vt,
                        input logic [15:0] es, input logic ec, input logic eo);
    a = va; b = vb; cin = vc; sub = vs; tag_in = vt; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({nm, "_rdy"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk({nm, "_lat0"}, out_valid, 0);
    tick();
    chk({nm, "_lat1"}, out_valid, 0);
    tick();
    chk({nm, "_vld"}, out_valid, 1);
    chk({nm, "_res"}, obs(), {vt, eo, ec, es});
    tick();
    chk({nm, "_drain"}, out_valid, 0);
  endtask

  task automatic run32(input string nm, input logic [31:0] va, input logic [31:0] vb,
                       input logic vc, input logic vs, input logic [3:0] vt,
                       input logic [31:0] es, input logic ec, input logic eo);
    xa = va; xb = vb; xcin = vc; xsub = vs; xtag_in = vt; xin_valid = 1'b1;
    #1 chk({nm, "_rdy"}, xin_ready, 1);
    tick();
    xin_valid = 1'b0;
    repeat (4) tick();
    chk({nm, "_lat"}, xout_valid, 0);
    tick();
    chk({nm, "_vld"}, xout_valid, 1);
    chk({nm, "_res"}, {xtag_out, xovf, xcout, xsum}, {vt, eo, ec, es});
    tick();
  endtask

  task automatic run13(input string nm, input logic [12:0] va, input logic [12:0] vb,
                       input logic vc, input logic vs, input logic [3:0] vt,
                       input logic [12:0] es, input logic ec, input logic eo);
    ya = va; yb = vb; ycin = vc; ysub = vs; ytag_in = vt; yin_valid = 1'b1;
    #1 chk({nm, "_rdy"}, yin_ready, 1);
    tick();
    yin_valid = 1'b0;
    chk({nm, "_lat"}, yout_valid, 0);
    tick();
    chk({nm, "_vld"}, yout_valid, 1);
    chk({nm, "_res"}, {ytag_out, yovf, ycout, ysum}, {vt, eo, ec, es});
    tick();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0; tag_in = '0;
    xin_valid = 1'b0; xout_ready = 1'b1; xa = '0; xb = '0; xcin = 1'b0; xsub = 1'b0; xtag_in = '0;
    yin_valid = 1'b0; yout_ready = 1'b1; ya = '0; yb = '0; ycin = 1'b0; ysub = 1'b0; ytag_in = '0;

    // reset state
    repeat (3) tick();
    chk("rst_rdy", in_ready, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_out", obs(), 0);
    chk("rst_vld32", xout_valid, 0);
    chk("rst_vld13", yout_valid, 0);
    rst = 1'b0;
    #1 chk("post_rst_rdy", in_ready, 1);

    // directed vectors, default build
    single("wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'd3, 16'h0000, 1'b1, 1'b0);
    single("povf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 4'd1, 16'h8000, 1'b0, 1'b1);
    single("sub_ci", 16'h0005, 16'h0007, 1'b1, 1'b1, 4'd2, 16'hFFFE, 1'b0, 1'b0);
    single("sub_nov",16'h8000, 16'h0001, 1'b0, 1'b1, 4'd7, 16'h7FFF, 1'b1, 1'b1);
    single("sub_0",  16'h0000, 16'h0000, 1'b0, 1'b1, 4'd9, 16'h0000, 1'b1, 1'b0);
    single("novf",   16'h8000, 16'h8000, 1'b0, 1'b0, 4'hA, 16'h0000, 1'b1, 1'b1);
    single("cin1",   16'h1234, 16'h4321, 1'b1, 1'b0, 4'hF, 16'h5556, 1'b0, 1'b0);

    // streaming, out_ready held high
    sb.delete(); sent = 0; got = 0; first = -1; last = -1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 230 && got < 200; cyc++) begin
      in_valid = (sent < 200);
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      tag_in = 4'($urandom);
      #1;
      if (in_valid) chk("strm_rdy", in_ready, 1);
      acc = in_valid & in_ready; xfr = out_valid & out_ready; cur = obs();
      exp_in = model(a, b, cin, sub, tag_in);
      tick();
      if (xfr) begin
        if (sb.size() == 0) chk("strm_extra", 1, 0);
        else chk("strm_data", cur, sb.pop_front());
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (acc) begin sb.push_back(exp_in); sent++; end
    end
    in_valid = 1'b0;
    chk("strm_count", got, 200);
    chk("strm_lat", first, 3);
    chk("strm_rate", last - first, 199);

    // backpressure with tags 0..4
    out_ready = 1'b0; b = 16'h0F0F; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 16'(i * 16'h1111); tag_in = 4'(i);
      #1 chk("bp_rdy", in_ready, 1);
      tick();
    end
    a = 16'h3333; tag_in = 4'd3;
    #1;
    chk("bp_full", in_ready, 0);
    chk("bp_out0", {out_valid, obs()}, {1'b1, model(16'h0000, 16'h0F0F, 1'b0, 1'b0, 4'd0)});
    held = obs();
    repeat (3) begin
      tick();
      chk("bp_hold", {out_valid, in_ready, obs()}, {2'b10, held});
    end
    out_ready = 1'b1;
    #1 chk("bp_release_rdy", in_ready, 1);
    tick();
    chk("bp_out1", {out_valid, obs()}, {1'b1, model(16'h1111, 16'h0F0F, 1'b0, 1'b0, 4'd1)});
    a = 16'h4444; tag_in = 4'd4;
    #1 chk("bp_rdy4", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_out2", {out_valid, obs()}, {1'b1, model(16'h2222, 16'h0F0F, 1'b0, 1'b0, 4'd2)});
    tick();
    chk("bp_out3", {out_valid, obs()}, {1'b1, model(16'h3333, 16'h0F0F, 1'b0, 1'b0, 4'd3)});
    tick();
    chk("bp_out4", {out_valid, obs()}, {1'b1, model(16'h4444, 16'h0F0F, 1'b0, 1'b0, 4'd4)});
    tick();
    chk("bp_empty", out_valid, 0);

    // random in_valid and out_ready
    sb.delete(); sent = 0; got = 0; stalled = 1'b0;
    for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
      if (stalled) chk("rnd_hold", {out_valid, obs()}, {1'b1, held});
      in_valid = (sent < 1000) && ($urandom_range(0, 1) == 1);
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      tag_in = 4'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      #1;
      acc = in_valid & in_ready; xfr = out_valid & out_ready; cur = obs();
      exp_in = model(a, b, cin, sub, tag_in);
      stalled = out_valid & ~out_ready; held = cur;
      tick();
      if (xfr) begin
        if (sb.size() == 0) chk("rnd_extra", 1, 0);
        else chk("rnd_data", cur, sb.pop_front());
        got++;
      end
      if (acc) begin sb.push_back(exp_in); sent++; end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("rnd_count", got, 1000);
    chk("rnd_left", sb.size(), 0);
    tick();
    tick();

    // reset with three operations in flight
    out_ready = 1'b0; in_valid = 1'b1; b = 16'h0101; cin = 1'b0; sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 16'(16'h0A00 + i); tag_in = 4'(8 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("inflight_full", {out_valid, in_ready}, 2'b10);
    rst = 1'b1;
    #1 chk("midrst_rdy", in_ready, 0);
    tick();
    chk("midrst_vld", out_valid, 0);
    chk("midrst_out", obs(), 0);
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("no_stale", out_valid, 0);
    end
    single("after_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 4'd6, 16'h0100, 1'b0, 1'b0);

    // other parameterisations
    run32("w32_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'd5, 32'h0000_0000, 1'b1, 1'b0);
    run32("w32_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'd6, 32'h8000_0000, 1'b0, 1'b1);
    run32("w32_sub",  32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 4'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run32("w32_cin",  32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 4'd8, 32'h2345_678A, 1'b0, 1'b0);
    run13("w13_wrap", 13'h1FFF, 13'h0001, 1'b0, 1'b0, 4'd1, 13'h0000, 1'b1, 1'b0);
    run13("w13_ovf",  13'h0FFF, 13'h0001, 1'b0, 1'b0, 4'd2, 13'h1000, 1'b0, 1'b1);
    run13("w13_sub",  13'h1000, 13'h0001, 1'b0, 1'b1, 4'd3, 13'h0FFF, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/ks_adder_pipe.md
Name: ks_adder_pipe

Overview:
- Pipelined, parametrised Kogge-Stone parallel-prefix adder/subtractor. It succeeds the single-cycle combinational 16-bit adder.
- Adds register stages between prefix levels and a valid/ready handshake with full backpressure.
- Adds a subtract mode, a signed-overflow flag and an opaque tag that travels with each operation.
- Sits in the datapath library and is driven by the existing driver/monitor bench structure, extended with handshake signals.

Parameters:
- WIDTH, 16: operand width in bits; must be >= 2. Prefix levels L = ceil(log2(WIDTH)).
- LVL_PER_STG, 2: prefix levels evaluated between consecutive pipeline registers; must be >= 1.
- TAG_W, 4: width of the sideband tag; must be >= 1.
- Derived NSTAGE = ceil(L/LVL_PER_STG) + 1. This gives 3 for the defaults.

Ports:
- clk, input, 1: single clock; everything is rising-edge.
- rst, input, 1: synchronous active-high reset.
- in_valid, input, 1: operation offered.
- in_ready, output, 1: block can accept this cycle.
- A, input, WIDTH: operand A.
- B, input, WIDTH: operand B.
- cin, input, 1: carry-in; ignored when sub=1.
- sub, input, 1: 0 = A+B+cin; 1 = A-B, computed as A+~B+1.
- tag_in, input, TAG_W: sideband tag, captured with the operands.
- out_valid, output, 1: result present.
- out_ready, input, 1: consumer accepts the result.
- sum, output, WIDTH: result.
- cout, output, 1: carry-out. In sub mode, 1 = no borrow.
- ovf, output, 1: signed overflow, equal to carry into the MSB XOR carry out of the MSB.
- tag_out, output, TAG_W: tag belonging to the presented result.

Behaviour:
- Reset: synchronous on rst=1 at a clock edge.
  - All stage valid bits clear; out_valid=0; sum, cout, ovf and tag_out are 0.
  - in_ready is forced to 0 while rst=1.
  - In-flight operations are discarded with no partial output.
  - First accept is possible in the cycle after rst falls.
- Stage 0 register: captures A, B' (B' = sub ? ~B : B), c0 (c0 = sub ? 1 : cin), the per-bit generate/propagate, and tag.
- Middle stages: each evaluates LVL_PER_STG Kogge-Stone levels (span 1,2,4,...) and registers the group G/P, original P, c0 and tag. The last stage may hold fewer levels.
- Final stage (NSTAGE-1):
  - sum[i] = P[i] XOR carry[i], with carry[0]=c0 and carry[i+1] = G[i:0] OR (P[i:0] AND c0).
  - cout = carry[WIDTH]; ovf = carry[WIDTH-1] XOR carry[WIDTH].
  - Outputs come directly from this register, with no combinational path from inputs to outputs.
- Handshake:
  - An accept occurs when in_valid and in_ready are both 1 at a clock edge.
  - A transfer occurs when out_valid and out_ready are both 1 at a clock edge.
  - Stage k advances iff stage k is valid and (stage k+1 is empty or stage k+1 advances). The last stage advances on a transfer.
  - in_ready = !rst and (stage 0 empty or stage 0 advances). This is a combinational path from out_ready that ripples through the stage chain.
  - Bubbles collapse: an empty stage accepts even while downstream is stalled.
- Latency and throughput:
  - An operation accepted at edge k shows out_valid=1 after edge k+NSTAGE-1, i.e. NSTAGE cycles after its accept cycle, when there is no stall.
  - Throughput is 1 operation per cycle when out_ready=1.
- Stall rules:
  - While out_valid=1 and out_ready=0, sum, cout, ovf and tag_out hold stable.
  - Up to NSTAGE operations are buffered; once all stages are full, in_ready=0.
- Ordering: results emerge in accept order, with the tag bound to its operands.
- Simultaneous events: accept and transfer in the same cycle while full is legal and sustains full throughput.
- in_valid may drop without an accept; the block holds no state for un-accepted offers.
- Wrap-around: sum is modulo 2^WIDTH. The carry is reported only via cout.

Test Plan:
- Defaults, A=0xFFFF, B=0x0001, cin=0, sub=0, tag=3 -> sum=0x0000, cout=1, ovf=0, tag_out=3, out_valid 3 cycles after the accept cycle.
- A=0x7FFF, B=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Then A=0x0005, B=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0 (cin ignored).
- Streaming: 200 random back-to-back ops with out_ready=1 -> one result per cycle, matching a reference model including cout/ovf/tag, with no in_ready drop.
- Backpressure: hold out_ready=0 and offer 5 ops with tags 0..4 -> exactly 3 accepted, then in_ready=0 and outputs stable. Raise out_ready -> tags 0,1,2 emerge on consecutive cycles, then tags 3,4 are accepted.
- Random out_ready (50%) with random in_valid over 1000 ops -> no loss, no duplication, order preserved, and outputs held while stalled.
- Assert rst for 1 cycle with 3 ops in flight -> out_valid=0 and outputs 0 the next cycle, in_ready=0 during rst, and no stale result appears afterwards. Also rerun the tests with WIDTH=32, LVL_PER_STG=1 (NSTAGE=6) and WIDTH=13, LVL_PER_STG=4 (NSTAGE=2).
